data_rd_ctrl: RTL

//  Read side of the data_cache. Takes a base read address (slot ID <<7) from the address manager,

---
 rtl/tsn_pkt_pkg.sv | 28 ++
 rtl/rd_lat_pipe.sv | 58 +++++
 rtl/data_rd_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/tsn_pkt_pkg.sv
// Shared definitions for the packet cache read path.
//  - Line geometry: DW-bit lines, AW-bit cache addresses split into
//    slot ID [AW-1:OFS_W] and line offset [OFS_W-1:0].
//  - Line type codes carried in the top two bits of every line.
//  - Read-controller FSM state encoding.
package tsn_pkt_pkg;

    localparam int DW     = 134;
    localparam int AW     = 12;
    localparam int OFS_W  = 7;
    localparam int SLOT_W = AW - OFS_W;

    localparam logic [1:0] PKT_HEAD = 2'b01;
    localparam logic [1:0] PKT_BODY = 2'b11;
    localparam logic [1:0] PKT_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    function automatic logic [1:0] line_type(input logic [DW-1:0] line);
        return line[DW-1:DW-2];
    endfunction

endpackage

// File: rtl/rd_lat_pipe.sv
// Tracks cache reads that are in flight between issue and data return.
// One stage per cycle of RAM latency; each stage holds {valid, last} where
// "last" marks the read of the final line offset of a slot.
// Ports:
//  clk, rst_n   clock, asynchronous active-low reset
//  issue        a read is issued this cycle
//  issue_last   the read issued this cycle targets the final offset
//  ret_valid    read data is on the RAM data bus this cycle
//  ret_last     the returning line is from the final offset
//  pipe_empty   no read in flight at all
//  pipe_clear   nothing in flight behind the returning stage, so the pipe
//               is empty next cycle unless a new read is issued
module rd_lat_pipe #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic issue,
    input  logic issue_last,
    output logic ret_valid,
    output logic ret_last,
    output logic pipe_empty,
    output logic pipe_clear
);

    logic [LAT-1:0] vld_q;
    logic [LAT-1:0] lst_q;

    // NOTE: the pipe is a handful of flops, so it is reset; an abandoned
    // packet must not leave stale returns that look like live data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            lst_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value, giving a true shift register.
            vld_q[0] <= issue;
            lst_q[0] <= issue & issue_last;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                lst_q[i] <= lst_q[i-1];
            end
        end
    end

    assign ret_valid  = vld_q[LAT-1];
    assign ret_last   = vld_q[LAT-1] & lst_q[LAT-1];
    assign pipe_empty = ~|vld_q;

    always_comb begin
        pipe_clear = 1'b1;
        for (int i = 0; i < LAT - 1; i++) begin
            if (vld_q[i]) pipe_clear = 1'b0;
        end
    end

endmodule

// File: rtl/data_rd_ctrl.sv
// Read side of the packet data cache. Given a slot base address, streams the
// slot's lines out of the cache RAM from offset 0 until a tail line (or the
// last offset of the slot), forwards each line downstream the cycle it
// returns, and pulses out_ram2addr_valid once the slot can be recycled.
// Ports:
//  clk, rst_n          clock, asynchronous active-low reset
//  in_raddr/_wr        slot base address and its one-cycle strobe
//  out_ram_raddr/_rd   cache RAM read address / enable
//  in_ram_rdata        cache RAM read data, RAM_LAT cycles after the read
//  in_pkt_alf          downstream almost-full, pauses new reads
//  out_pkt_data/_wr    packet line to downstream and its qualifier
//  out_ram2addr_valid  one-cycle pulse, packet fully sent
//  out_rd_err          one-cycle pulse on a protocol error
module data_rd_ctrl
    import tsn_pkt_pkg::*;
#(
    parameter int RAM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] in_raddr,
    input  logic          in_raddr_wr,
    output logic [AW-1:0] out_ram_raddr,
    output logic          out_ram_rd,
    input  logic [DW-1:0] in_ram_rdata,
    input  logic          in_pkt_alf,
    output logic [DW-1:0] out_pkt_data,
    output logic          out_pkt_data_wr,
    output logic          out_ram2addr_valid,
    output logic          out_rd_err
);

    rd_state_e          state_q, state_d;
    logic [SLOT_W-1:0]  base_q;
    logic [OFS_W-1:0]   ofs_q;
    logic               tail_sent_q;   // packet's tail already forwarded
    logic               first_q;       // next returned line is the first

    logic        ret_valid, ret_last, pipe_empty, pipe_clear;
    logic [1:0]  ret_type;
    logic        fwd, ret_tail, force_tail, line_end;
    logic        head_err, busy_err, rd;
    logic        issue_last;

    rd_lat_pipe #(.LAT(RAM_LAT)) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue      (rd),
        .issue_last (issue_last),
        .ret_valid  (ret_valid),
        .ret_last   (ret_last),
        .pipe_empty (pipe_empty),
        .pipe_clear (pipe_clear)
    );

    // The low address bits are zero by construction and pipe_empty is implied
    // by the DONE state; both are intentionally not consumed.
    logic unused_ok;
    assign unused_ok = ^{in_raddr[OFS_W-1:0], pipe_empty};

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        ret_type   = line_type(in_ram_rdata);
        // Returns after the tail (reads that were already in flight) are dropped.
        fwd        = ret_valid && !tail_sent_q &&
                     (state_q == ST_READ || state_q == ST_DRAIN);
        ret_tail   = fwd && (ret_type == PKT_TAIL);
        force_tail = fwd && ret_last && (ret_type != PKT_TAIL);
        line_end   = ret_tail || force_tail;
        head_err   = fwd && first_q && (ret_type != PKT_HEAD);
        busy_err   = in_raddr_wr && (state_q != ST_IDLE);
        // A tail returning this cycle already ends the packet: stop reading now.
        rd         = (state_q == ST_READ) && !in_pkt_alf && !line_end;
        issue_last = (ofs_q == '1);

        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_raddr_wr) state_d = ST_READ;
            ST_READ: begin
                if (line_end)                state_d = pipe_clear ? ST_DONE : ST_DRAIN;
                else if (rd && issue_last)   state_d = ST_DRAIN;
            end
            ST_DRAIN: if (pipe_clear) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            ofs_q       <= '0;
            tail_sent_q <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && in_raddr_wr) begin
                base_q      <= in_raddr[AW-1:OFS_W];
                ofs_q       <= '0;
                tail_sent_q <= 1'b0;
                first_q     <= 1'b1;
            end else begin
                if (rd)       ofs_q       <= ofs_q + 1'b1;
                if (fwd)      first_q     <= 1'b0;
                if (line_end) tail_sent_q <= 1'b1;
            end
        end
    end

    assign out_ram_rd         = rd;
    assign out_ram_raddr      = rd ? {base_q, ofs_q} : '0;
    assign out_pkt_data_wr    = fwd;
    assign out_pkt_data       = !fwd      ? '0 :
                                force_tail ? {PKT_TAIL, in_ram_rdata[DW-3:0]} :
                                             in_ram_rdata;
    assign out_ram2addr_valid = (state_q == ST_DONE);
    assign out_rd_err         = head_err || force_tail || busy_err;

endmodule
